// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: groups the pipeline-to-hazard-unit signals.
//   master : pipeline side (drives register ids, load/branch flags and the
//            cache request/response handshakes; receives stage enables)
//   slave  : hazard controller side
interface hazard_ctrl_if;

    // Register ids (rv32i_reg)
    logic [4:0] rs1_ID;
    logic [4:0] rs2_ID;
    logic [4:0] rd_EX;

    // Instruction status from EX
    logic       mem_read_EX;
    logic       br_taken_EX;

    // Cache handshakes (response is a one-cycle pulse)
    logic       imem_read;
    logic       imem_resp;
    logic       dmem_access;
    logic       dmem_resp;

    // Stage register enables and bubble insertion
    logic       load_pc;
    logic       load_IF_ID;
    logic       load_ID_EX;
    logic       load_EX_MEM;
    logic       load_MEM_WB;
    logic       flush_IF_ID;
    logic       flush_ID_EX;

    modport master (
        output rs1_ID, rs2_ID, rd_EX, mem_read_EX, br_taken_EX,
               imem_read, imem_resp, dmem_access, dmem_resp,
        input  load_pc, load_IF_ID, load_ID_EX, load_EX_MEM, load_MEM_WB,
               flush_IF_ID, flush_ID_EX
    );

    modport slave (
        input  rs1_ID, rs2_ID, rd_EX, mem_read_EX, br_taken_EX,
               imem_read, imem_resp, dmem_access, dmem_resp,
        output load_pc, load_IF_ID, load_ID_EX, load_EX_MEM, load_MEM_WB,
               flush_IF_ID, flush_ID_EX
    );

endinterface : hazard_ctrl_if

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush controller for a 5-stage RV32I pipeline.
// Priority: cache stall (full freeze) > taken branch (flush IF/ID and ID/EX)
//           > load-use (one bubble into ID/EX) > normal flow.
// Stage controls are combinational from current inputs and state.
// Optional build macro HAZARD_PERF_CNT_EN adds three 32-bit event counters
// (mem_stall_cnt, lu_stall_cnt, flush_cnt); the default build omits them.
module hazard_ctrl (
    input  logic              clk,
    input  logic              rst,
    hazard_ctrl_if.slave      hz
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]       mem_stall_cnt,
    output logic [31:0]       lu_stall_cnt,
    output logic [31:0]       flush_cnt
`endif
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        MEM_WAIT  = 2'd1,
        LU_BUBBLE = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic   imem_done_q, imem_done_d;
    logic   dmem_done_q, dmem_done_d;

    logic   mem_stall;
    logic   load_use_raw;
    logic   load_use;
    logic   advance;

    logic   load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
    logic   flush_if_id, flush_id_ex;

    // Hazard detection: outstanding cache requests and load-use dependency.
    // A *_done flag remembers a response that arrived while the pipeline was
    // frozen for the other cache, so that request no longer blocks.
    always_comb begin
        mem_stall    = (hz.imem_read   & ~(hz.imem_resp | imem_done_q))
                     | (hz.dmem_access & ~(hz.dmem_resp | dmem_done_q));
        load_use_raw = hz.mem_read_EX & (hz.rd_EX != 5'd0)
                     & ((hz.rd_EX == hz.rs1_ID) | (hz.rd_EX == hz.rs2_ID));
        // The bubble has already been inserted; EX may still hold the stale
        // load for this cycle, so never insert a second one.
        load_use     = load_use_raw & (state_q != LU_BUBBLE);
    end

    // Stage enables and flushes, chosen by priority.
    // NOTE: every output gets a default first so no path leaves a latch.
    always_comb begin
        load_pc     = 1'b1;
        load_if_id  = 1'b1;
        load_id_ex  = 1'b1;
        load_ex_mem = 1'b1;
        load_mem_wb = 1'b1;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        if (rst) begin
            load_pc     = 1'b0;
            load_if_id  = 1'b0;
            load_id_ex  = 1'b0;
            load_ex_mem = 1'b0;
            load_mem_wb = 1'b0;
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
        end else if (mem_stall) begin
            load_pc     = 1'b0;
            load_if_id  = 1'b0;
            load_id_ex  = 1'b0;
            load_ex_mem = 1'b0;
            load_mem_wb = 1'b0;
        end else if (hz.br_taken_EX) begin
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
        end else if (load_use) begin
            load_pc     = 1'b0;
            load_if_id  = 1'b0;
            flush_id_ex = 1'b1;
        end
    end

    assign advance        = load_mem_wb;

    assign hz.load_pc     = load_pc;
    assign hz.load_IF_ID  = load_if_id;
    assign hz.load_ID_EX  = load_id_ex;
    assign hz.load_EX_MEM = load_ex_mem;
    assign hz.load_MEM_WB = load_mem_wb;
    assign hz.flush_IF_ID = flush_if_id;
    assign hz.flush_ID_EX = flush_id_ex;

    // Next state for the FSM and the cache done flags.
    always_comb begin
        state_d     = state_q;
        imem_done_d = imem_done_q;
        dmem_done_d = dmem_done_q;

        if (mem_stall)
            state_d = MEM_WAIT;
        else if (hz.br_taken_EX)
            state_d = RUN;
        else if (load_use)
            state_d = LU_BUBBLE;
        else
            state_d = RUN;

        if (advance) begin
            imem_done_d = 1'b0;
            dmem_done_d = 1'b0;
        end else begin
            if (hz.imem_resp) imem_done_d = 1'b1;
            if (hz.dmem_resp) dmem_done_d = 1'b1;
        end
    end

    // State registers; synchronous reset also discards a same-cycle response.
    // NOTE: sequential state uses non-blocking assignment only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            imem_done_q <= 1'b0;
            dmem_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            imem_done_q <= imem_done_d;
            dmem_done_q <= dmem_done_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] mem_stall_cnt_q, mem_stall_cnt_d;
    logic [31:0] lu_stall_cnt_q,  lu_stall_cnt_d;
    logic [31:0] flush_cnt_q,     flush_cnt_d;

    // Event counters: freeze cycles, load-use bubbles, branch flushes.
    // Each wraps naturally from all-ones to zero.
    always_comb begin
        mem_stall_cnt_d = mem_stall_cnt_q;
        lu_stall_cnt_d  = lu_stall_cnt_q;
        flush_cnt_d     = flush_cnt_q;
        if (mem_stall)
            mem_stall_cnt_d = mem_stall_cnt_q + 32'd1;
        else if (hz.br_taken_EX)
            flush_cnt_d     = flush_cnt_q + 32'd1;
        else if (load_use)
            lu_stall_cnt_d  = lu_stall_cnt_q + 32'd1;
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_stall_cnt_q <= 32'd0;
            lu_stall_cnt_q  <= 32'd0;
            flush_cnt_q     <= 32'd0;
        end else begin
            mem_stall_cnt_q <= mem_stall_cnt_d;
            lu_stall_cnt_q  <= lu_stall_cnt_d;
            flush_cnt_q     <= flush_cnt_d;
        end
    end

    assign mem_stall_cnt = mem_stall_cnt_q;
    assign lu_stall_cnt  = lu_stall_cnt_q;
    assign flush_cnt     = flush_cnt_q;
`endif

endmodule : hazard_ctrl

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed checks of hazard_ctrl stall/flush priority,
// load-use bubble, dual-cache freeze, reset behaviour and (when built with
// HAZARD_PERF_CNT_EN) the event counters.
module tb_hazard_ctrl;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    hazard_ctrl_if hz ();

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] mem_stall_cnt, lu_stall_cnt, flush_cnt;
`endif

    hazard_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .hz            (hz)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .mem_stall_cnt (mem_stall_cnt),
        .lu_stall_cnt  (lu_stall_cnt),
        .flush_cnt     (flush_cnt)
`endif
    );

    // {load_pc, load_IF_ID, load_ID_EX, load_EX_MEM, load_MEM_WB, flush_IF_ID, flush_ID_EX}
    wire [6:0] ctl = {hz.load_pc, hz.load_IF_ID, hz.load_ID_EX, hz.load_EX_MEM,
                      hz.load_MEM_WB, hz.flush_IF_ID, hz.flush_ID_EX};

    localparam logic [6:0] C_NORMAL = 7'b11111_00;
    localparam logic [6:0] C_FREEZE = 7'b00000_00;
    localparam logic [6:0] C_BRANCH = 7'b11111_11;
    localparam logic [6:0] C_BUBBLE = 7'b00111_01;
    localparam logic [6:0] C_RESET  = 7'b00000_11;

    int checks = 0;
    int errors = 0;

    // Advance to just after the next rising edge, where inputs are changed.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle before sampling, clear of the edge.
    task automatic settle();
        #2;
    endtask

    task automatic clear_inputs();
        hz.rs1_ID      = 5'd1;
        hz.rs2_ID      = 5'd2;
        hz.rd_EX       = 5'd3;
        hz.mem_read_EX = 1'b0;
        hz.br_taken_EX = 1'b0;
        hz.imem_read   = 1'b0;
        hz.imem_resp   = 1'b0;
        hz.dmem_access = 1'b0;
        hz.dmem_resp   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        settle();
        checks++;
        if (ctl !== C_RESET) begin
            errors++;
            $display("FAIL reset_idle ctl=%b exp=%b", ctl, C_RESET);
        end
        // Load-use and branch inputs are ignored while reset is high.
        hz.rd_EX = 5'd5; hz.rs1_ID = 5'd5; hz.mem_read_EX = 1'b1; hz.br_taken_EX = 1'b1;
        settle();
        checks++;
        if (ctl !== C_RESET) begin
            errors++;
            $display("FAIL reset_override ctl=%b exp=%b", ctl, C_RESET);
        end
        step();
        step();
        rst = 1'b0;
        clear_inputs();
        settle();
        checks++;
        if (ctl !== C_NORMAL) begin
            errors++;
            $display("FAIL reset_release ctl=%b exp=%b", ctl, C_NORMAL);
        end
        step();
    endtask

    task automatic test_load_use();
        // rs1 match: one bubble, then normal even with stale EX fields.
        hz.rd_EX = 5'd5; hz.mem_read_EX = 1'b1; hz.rs1_ID = 5'd5;
        settle();
        checks++;
        if (ctl !== C_BUBBLE) begin
            errors++;
            $display("FAIL lu_rs1_bubble ctl=%b exp=%b", ctl, C_BUBBLE);
        end
        step();
        settle();
        checks++;
        if (ctl !== C_NORMAL) begin
            errors++;
            $display("FAIL lu_no_double_bubble ctl=%b exp=%b", ctl, C_NORMAL);
        end
        step();
        // rs2 match.
        clear_inputs();
        hz.rd_EX = 5'd7; hz.mem_read_EX = 1'b1; hz.rs2_ID = 5'd7;
        settle();
        checks++;
        if (ctl !== C_BUBBLE) begin
            errors++;
            $display("FAIL lu_rs2_bubble ctl=%b exp=%b", ctl, C_BUBBLE);
        end
        step();
        clear_inputs();
        settle();
        checks++;
        if (ctl !== C_NORMAL) begin
            errors++;
            $display("FAIL lu_rs2_after ctl=%b exp=%b", ctl, C_NORMAL);
        end
        step();
    endtask

    task automatic test_no_hazard();
        // x0 destination never creates a dependency.
        hz.rd_EX = 5'd0; hz.mem_read_EX = 1'b1; hz.rs1_ID = 5'd0;
        settle();
        checks++;
        if (ctl !== C_NORMAL) begin
            errors++;
            $display("FAIL lu_x0 ctl=%b exp=%b", ctl, C_NORMAL);
        end
        step();
        // Matching registers but not a load.
        hz.rd_EX = 5'd9; hz.mem_read_EX = 1'b0; hz.rs1_ID = 5'd9; hz.rs2_ID = 5'd9;
        settle();
        checks++;
        if (ctl !== C_NORMAL) begin
            errors++;
            $display("FAIL lu_not_load ctl=%b exp=%b", ctl, C_NORMAL);
        end
        step();
        clear_inputs();
    endtask

    task automatic test_dual_stall();
        logic [6:0] exp_ctl;
        logic       exp_done;
        hz.imem_read   = 1'b1;
        hz.dmem_access = 1'b1;
        for (int c = 0; c <= 6; c++) begin
            hz.dmem_resp = (c == 2);
            hz.imem_resp = (c == 5);
            settle();
            exp_ctl  = (c == 5) ? C_NORMAL : C_FREEZE;
            exp_done = (c >= 3 && c <= 5);
            checks++;
            if (ctl !== exp_ctl) begin
                errors++;
                $display("FAIL dual_stall_c%0d ctl=%b exp=%b", c, ctl, exp_ctl);
            end
            if (c >= 2) begin
                checks++;
                if (dut.dmem_done_q !== exp_done) begin
                    errors++;
                    $display("FAIL dmem_done_c%0d got=%b exp=%b", c, dut.dmem_done_q, exp_done);
                end
            end
            step();
        end
        clear_inputs();
        settle();
        checks++;
        if (ctl !== C_NORMAL) begin
            errors++;
            $display("FAIL dual_stall_drop ctl=%b exp=%b", ctl, C_NORMAL);
        end
        step();
    endtask

    task automatic test_simultaneous_resp();
        hz.imem_read = 1'b1; hz.dmem_access = 1'b1;
        settle();
        checks++;
        if (ctl !== C_FREEZE) begin
            errors++;
            $display("FAIL simul_wait ctl=%b exp=%b", ctl, C_FREEZE);
        end
        step();
        hz.imem_resp = 1'b1; hz.dmem_resp = 1'b1;
        settle();
        checks++;
        if (ctl !== C_NORMAL) begin
            errors++;
            $display("FAIL simul_release ctl=%b exp=%b", ctl, C_NORMAL);
        end
        step();
        clear_inputs();
    endtask

    task automatic test_branch();
        // Branch beats load-use.
        hz.br_taken_EX = 1'b1; hz.rd_EX = 5'd5; hz.mem_read_EX = 1'b1; hz.rs1_ID = 5'd5;
        settle();
        checks++;
        if (ctl !== C_BRANCH) begin
            errors++;
            $display("FAIL br_over_lu ctl=%b exp=%b", ctl, C_BRANCH);
        end
        step();
        clear_inputs();
        settle();
        checks++;
        if (ctl !== C_NORMAL) begin
            errors++;
            $display("FAIL br_after ctl=%b exp=%b", ctl, C_NORMAL);
        end
        step();
        // Memory stall beats branch; flush once dmem responds.
        hz.br_taken_EX = 1'b1; hz.rd_EX = 5'd5; hz.mem_read_EX = 1'b1; hz.rs1_ID = 5'd5;
        hz.dmem_access = 1'b1;
        for (int c = 0; c < 2; c++) begin
            settle();
            checks++;
            if (ctl !== C_FREEZE) begin
                errors++;
                $display("FAIL br_mem_wait_c%0d ctl=%b exp=%b", c, ctl, C_FREEZE);
            end
            step();
        end
        hz.dmem_resp = 1'b1;
        settle();
        checks++;
        if (ctl !== C_BRANCH) begin
            errors++;
            $display("FAIL br_mem_release ctl=%b exp=%b", ctl, C_BRANCH);
        end
        step();
        clear_inputs();
    endtask

    task automatic test_lu_after_stall();
        // Load-use held behind a dmem stall: freeze, then exactly one bubble.
        hz.rd_EX = 5'd4; hz.mem_read_EX = 1'b1; hz.rs2_ID = 5'd4; hz.dmem_access = 1'b1;
        settle();
        checks++;
        if (ctl !== C_FREEZE) begin
            errors++;
            $display("FAIL lu_stall_wait ctl=%b exp=%b", ctl, C_FREEZE);
        end
        step();
        hz.dmem_resp = 1'b1;
        settle();
        checks++;
        if (ctl !== C_BUBBLE) begin
            errors++;
            $display("FAIL lu_stall_bubble ctl=%b exp=%b", ctl, C_BUBBLE);
        end
        step();
        hz.dmem_resp = 1'b0; hz.dmem_access = 1'b0;
        settle();
        checks++;
        if (ctl !== C_NORMAL) begin
            errors++;
            $display("FAIL lu_stall_after ctl=%b exp=%b", ctl, C_NORMAL);
        end
        step();
        clear_inputs();
    endtask

    task automatic test_reset_mid_stall();
        hz.imem_read = 1'b1; hz.dmem_access = 1'b1;
        settle();
        step();
        hz.dmem_resp = 1'b1;
        settle();
        step();
        hz.dmem_resp = 1'b0;
        settle();
        checks++;
        if (dut.dmem_done_q !== 1'b1) begin
            errors++;
            $display("FAIL rst_stall_setup got=%b exp=1", dut.dmem_done_q);
        end
        // Reset with a same-cycle imem response that must be discarded.
        rst = 1'b1; hz.imem_resp = 1'b1;
        settle();
        checks++;
        if (ctl !== C_RESET) begin
            errors++;
            $display("FAIL rst_stall_ctl ctl=%b exp=%b", ctl, C_RESET);
        end
        step();
        rst = 1'b0; hz.imem_resp = 1'b0;
        settle();
        checks++;
        if ({dut.imem_done_q, dut.dmem_done_q} !== 2'b00) begin
            errors++;
            $display("FAIL rst_stall_flags got=%b exp=00", {dut.imem_done_q, dut.dmem_done_q});
        end
        checks++;
        if (dut.state_q !== 2'd0) begin
            errors++;
            $display("FAIL rst_stall_state got=%0d exp=0", dut.state_q);
        end
        checks++;
        if (ctl !== C_FREEZE) begin
            errors++;
            $display("FAIL rst_stall_refreeze ctl=%b exp=%b", ctl, C_FREEZE);
        end
        step();
        clear_inputs();
        settle();
        step();
    endtask

`ifdef HAZARD_PERF_CNT_EN
    task automatic test_perf_cnt();
        rst = 1'b1;
        clear_inputs();
        step();
        rst = 1'b0;
        hz.dmem_access = 1'b1;
        step();
        step();
        step();
        hz.dmem_access = 1'b0;
        settle();
        checks++;
        if (mem_stall_cnt !== 32'd3) begin
            errors++;
            $display("FAIL cnt_mem_stall got=%0d exp=3", mem_stall_cnt);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        settle();
        checks++;
        if (mem_stall_cnt !== 32'd0) begin
            errors++;
            $display("FAIL cnt_mem_rst got=%0d exp=0", mem_stall_cnt);
        end
        hz.rd_EX = 5'd6; hz.mem_read_EX = 1'b1; hz.rs1_ID = 5'd6;
        step();
        clear_inputs();
        hz.br_taken_EX = 1'b1;
        step();
        clear_inputs();
        settle();
        checks++;
        if ({lu_stall_cnt, flush_cnt, mem_stall_cnt} !== {32'd1, 32'd1, 32'd0}) begin
            errors++;
            $display("FAIL cnt_lu_flush got=%0d/%0d/%0d exp=1/1/0",
                     lu_stall_cnt, flush_cnt, mem_stall_cnt);
        end
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_load_use();
        test_no_hazard();
        test_dual_stall();
        test_simultaneous_resp();
        test_branch();
        test_lu_after_stall();
        test_reset_mid_stall();
`ifdef HAZARD_PERF_CNT_EN
        test_perf_cnt();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_hazard_ctrl
